// File: rtl/usb_pkg.sv
// Shared definitions for the USB token receiver: PID codes, FSM states,
// error codes and the CRC5 residual expected after a clean token.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;

  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA1   = 3'd1,
    ST_DATA2   = 3'd2,
    ST_EOPW    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_PID  = 2'd0,
    ERR_CRC  = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_LINE = 2'd3
  } err_code_t;

endpackage

// File: rtl/usb_token_rx.sv
// USB token packet receiver: PID check, address/endpoint capture, CRC5 residual check.
// Define USB_TOKEN_SOF_EN to accept SOF tokens; otherwise SOF is a PID error.
module usb_token_rx
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eop,
  input  logic       rx_err,
  output logic [7:0] crc_data,
  output logic       crc_en,
  output logic       crc_clr,
  input  logic [4:0] crc_in,
  output logic       tok_valid,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       tok_err,
  output logic [1:0] err_code
);

  state_t    r_state;
  err_code_t r_pend;
  logic      w_sof_ok;
  logic      w_pid_ok;
  logic      w_data_st;

`ifdef USB_TOKEN_SOF_EN
  assign w_sof_ok = 1'b1;
`else
  assign w_sof_ok = 1'b0;
`endif

  assign w_pid_ok = (rx_data[7:4] == ~rx_data[3:0]) &&
                    ((rx_data[3:0] == PID_OUT) || (rx_data[3:0] == PID_IN) ||
                     (rx_data[3:0] == PID_SETUP) ||
                     ((rx_data[3:0] == PID_SOF) && w_sof_ok));

  assign w_data_st = (r_state == ST_DATA1) || (r_state == ST_DATA2);

  // CRC stage controls act in the byte's own cycle so the registered crc_in
  // already covers both data bytes by the time rx_eop arrives.
  assign crc_en   = !rst && rx_valid && !rx_err && w_data_st;
  assign crc_data = crc_en ? rx_data : 8'h00;
  assign crc_clr  = !rst && rx_valid && (r_state == ST_IDLE) && w_pid_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pend    <= ERR_PID;
      tok_valid <= 1'b0;
      tok_err   <= 1'b0;
      err_code  <= 2'd0;
      tok_pid   <= 4'd0;
      tok_addr  <= 7'd0;
      tok_endp  <= 4'd0;
    end else begin
      tok_valid <= 1'b0;
      tok_err   <= 1'b0;
      if ((r_state != ST_IDLE) && rx_err) begin
        r_state <= ST_DISCARD;
        r_pend  <= ERR_LINE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (rx_valid) begin
              if (w_pid_ok) begin
                tok_pid <= rx_data[3:0];
                r_state <= ST_DATA1;
              end else begin
                r_pend  <= ERR_PID;
                r_state <= ST_DISCARD;
              end
            end
          end
          ST_DATA1: begin
            if (rx_eop) begin
              tok_err  <= 1'b1;
              err_code <= ERR_LEN;
              r_state  <= ST_IDLE;
            end else if (rx_valid) begin
              tok_addr    <= rx_data[6:0];
              tok_endp[0] <= rx_data[7];
              r_state     <= ST_DATA2;
            end
          end
          ST_DATA2: begin
            if (rx_eop) begin
              tok_err  <= 1'b1;
              err_code <= ERR_LEN;
              r_state  <= ST_IDLE;
            end else if (rx_valid) begin
              tok_endp[3:1] <= rx_data[2:0];
              r_state       <= ST_EOPW;
            end
          end
          ST_EOPW: begin
            // The residual verdict is registered on entry to CHECK so the
            // result pulse is visible during the CHECK cycle itself.
            if (rx_eop) begin
              r_state <= ST_CHECK;
              if (crc_in == CRC5_RESIDUAL) begin
                tok_valid <= 1'b1;
              end else begin
                tok_err  <= 1'b1;
                err_code <= ERR_CRC;
              end
            end else if (rx_valid) begin
              r_pend  <= ERR_LEN;
              r_state <= ST_DISCARD;
            end
          end
          ST_CHECK: r_state <= ST_IDLE;
          ST_DISCARD: begin
            if (rx_eop) begin
              tok_err  <= 1'b1;
              err_code <= r_pend;
              r_state  <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// Self-checking bench for usb_token_rx: packet-level outcome model plus directed packets.
// Expectations for SOF follow USB_TOKEN_SOF_EN as compiled.
module tb_usb_token_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_err;
  logic [7:0] crc_data;
  logic       crc_en;
  logic       crc_clr;
  logic [4:0] crc_in;
  logic       tok_valid;
  logic [3:0] tok_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       tok_err;
  logic [1:0] err_code;

  usb_token_rx dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_eop(rx_eop), .rx_err(rx_err), .crc_data(crc_data), .crc_en(crc_en),
    .crc_clr(crc_clr), .crc_in(crc_in), .tok_valid(tok_valid), .tok_pid(tok_pid),
    .tok_addr(tok_addr), .tok_endp(tok_endp), .tok_err(tok_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_valid;
    logic [1:0] code;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_en     = 0;
  int n_clr    = 0;
  int exp_clr  = 0;
  int n_tokv   = 0;
  logic [1:0] last_code = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Output monitor: every CRC enable and every token pulse is matched to the model.
  always @(negedge clk) begin : cmp
    ev_t        ev;
    logic [7:0] e;
    if (crc_en) begin
      n_en++;
      if (exp_q.size() == 0) chk("crc_en_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("crc_data", {24'd0, crc_data}, {24'd0, e});
      end
    end
    if (crc_clr) n_clr++;
    if (tok_valid || tok_err) begin
      chk("valid_err_exclusive", {31'd0, tok_valid && tok_err}, 32'd0);
      last_code = err_code;
      if (tok_valid) n_tokv++;
      if (ev_q.size() == 0) chk("tok_unexpected", 32'd1, 32'd0);
      else begin
        ev = ev_q.pop_front();
        chk("tok_cycle", cyc, ev.cyc);
        chk("tok_kind", {31'd0, tok_valid}, {31'd0, ev.is_valid});
        if (ev.is_valid) begin
          chk("tok_pid", {28'd0, tok_pid}, {28'd0, ev.pid});
          chk("tok_addr", {25'd0, tok_addr}, {25'd0, ev.addr});
          chk("tok_endp", {28'd0, tok_endp}, {28'd0, ev.endp});
        end else begin
          chk("err_code", {30'd0, err_code}, {30'd0, ev.code});
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic er);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
    rx_eop   = e;
    rx_err   = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic bit pid_accepted(input logic [7:0] p);
    bit sof_ok;
`ifdef USB_TOKEN_SOF_EN
    sof_ok = 1'b1;
`else
    sof_ok = 1'b0;
`endif
    return (p[7:4] == ~p[3:0]) &&
           (p[3:0] inside {4'h1, 4'h9, 4'hD} || (p[3:0] == 4'h5 && sof_ok));
  endfunction

  // Sends n bytes (slot err_at replaced by an rx_err pulse, -1 for none), then rx_eop.
  task automatic run_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int n, input int err_at,
                            input logic [4:0] crc);
    logic [7:0] b[4];
    bit         ok;
    ev_t        ev;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    ok = pid_accepted(b0);
    crc_in = crc;
    ev.is_valid = 1'b0;
    ev.code     = 2'd0;
    ev.pid      = b0[3:0];
    ev.addr     = b1[6:0];
    ev.endp     = {b2[2:0], b1[7]};
    if (err_at > 0)           ev.code = 2'd3;
    else if (!ok)             ev.code = 2'd0;
    else if (n != 3)          ev.code = 2'd2;
    else if (crc == 5'b01100) ev.is_valid = 1'b1;
    else                      ev.code = 2'd1;
    if (ok) begin
      exp_clr++;
      for (int i = 1; i < n && i <= 2; i++)
        if (err_at < 0 || i < err_at) exp_q.push_back(b[i]);
    end
    for (int i = 0; i < n; i++) begin
      if (i == err_at) drive(1'b0, 8'h00, 1'b0, 1'b1);
      else             drive(1'b1, b[i], 1'b0, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    ev.cyc = cyc + 1;
    ev_q.push_back(ev);
    idle(3);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tok_valid"}, {31'd0, tok_valid}, 32'd0);
    chk({tag, "_tok_err"},   {31'd0, tok_err}, 32'd0);
    chk({tag, "_crc_en"},    {31'd0, crc_en}, 32'd0);
    chk({tag, "_crc_clr"},   {31'd0, crc_clr}, 32'd0);
    chk({tag, "_tok_pid"},   {28'd0, tok_pid}, 32'd0);
    chk({tag, "_tok_addr"},  {25'd0, tok_addr}, 32'd0);
    chk({tag, "_tok_endp"},  {28'd0, tok_endp}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_eop = 1'b0; rx_err = 1'b0;
    crc_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset_init");
    rst = 1'b0;
    idle(2);

    // Good OUT token: pid 1, addr 3A, endp A
    run_packet(8'hE1, 8'h3A, 8'h05, 8'h00, 3, -1, 5'b01100);
    chk("good_pid_lit",  {28'd0, tok_pid}, 32'h1);
    chk("good_addr_lit", {25'd0, tok_addr}, 32'h3A);
    chk("good_endp_lit", {28'd0, tok_endp}, 32'hA);
    chk("good_count",    n_tokv, 1);

    // Same packet with a bad CRC residual
    run_packet(8'hE1, 8'h3A, 8'h05, 8'h00, 3, -1, 5'b00000);
    chk("crc_code_lit",   {30'd0, last_code}, 32'd1);
    chk("crc_no_valid",   n_tokv, 1);

    // PID complement mismatch: no CRC updates at all
    base = n_en;
    run_packet(8'hE2, 8'h00, 8'h00, 8'h00, 1, -1, 5'b01100);
    chk("pid_code_lit", {30'd0, last_code}, 32'd0);
    chk("pid_no_crc_en", n_en - base, 0);

    // Short IN token
    run_packet(8'h69, 8'h12, 8'h00, 8'h00, 2, -1, 5'b01100);
    chk("short_code_lit", {30'd0, last_code}, 32'd2);

    // Reset mid-packet, with a valid PID presented while reset is held
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    exp_clr++;
    drive(1'b1, 8'h3A, 1'b0, 1'b0);
    exp_q.push_back(8'h3A);
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_outputs_zero("reset_mid");
    @(posedge clk);
    #1;
    chk_outputs_zero("reset_hold");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    base = n_tokv;
    run_packet(8'h69, 8'h85, 8'h0B, 8'h00, 3, -1, 5'b01100);
    chk("after_reset_one_valid", n_tokv - base, 1);
    chk("after_reset_addr_lit", {25'd0, tok_addr}, 32'h05);
    chk("after_reset_endp_lit", {28'd0, tok_endp}, 32'h7);

    // SOF token, outcome depends on build option
    base = n_tokv;
    run_packet(8'hA5, 8'h34, 8'h02, 8'h00, 3, -1, 5'b01100);
`ifdef USB_TOKEN_SOF_EN
    chk("sof_valid", n_tokv - base, 1);
`else
    chk("sof_pid_err", {30'd0, last_code}, 32'd0);
    chk("sof_no_valid", n_tokv - base, 0);
`endif

    // Line error in the second data slot of a SETUP token
    run_packet(8'h2D, 8'h11, 8'h22, 8'h00, 3, 2, 5'b01100);
    chk("line_code_lit", {30'd0, last_code}, 32'd3);

    // Extra byte after the token payload
    run_packet(8'hE1, 8'h3A, 8'h05, 8'h77, 4, -1, 5'b01100);
    chk("extra_code_lit", {30'd0, last_code}, 32'd2);

    // All-ones payload bits
    run_packet(8'hE1, 8'hFF, 8'h07, 8'h00, 3, -1, 5'b01100);
    chk("ones_addr_lit", {25'd0, tok_addr}, 32'h7F);
    chk("ones_endp_lit", {28'd0, tok_endp}, 32'hF);

    idle(3);
    chk("token_events_left", ev_q.size(), 0);
    chk("crc_bytes_left", exp_q.size(), 0);
    chk("crc_clr_count", n_clr, exp_clr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_token_rx.md
USB_TOKEN_RX -- requirements
Module: usb_token_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port rx_data, input, 8 bits: received byte, valid only while rx_valid is high.
REQ-004 SHALL have port rx_valid, input, 1 bit: one-cycle byte strobe.
REQ-005 SHALL have port rx_eop, input, 1 bit: one-cycle end-of-packet pulse; never coincident with rx_valid.
REQ-006 SHALL have port rx_err, input, 1 bit: one-cycle line error pulse (bit-stuff/decode error).
REQ-007 SHALL have port crc_data, output, 8 bits: byte forwarded to the downstream CRC5 stage.
REQ-008 SHALL have port crc_en, output, 1 bit: CRC5 stage update enable.
REQ-009 SHALL have port crc_clr, output, 1 bit: CRC5 stage reinitialise pulse.
REQ-010 SHALL have port crc_in, input, 5 bits: registered CRC5 stage output.
REQ-011 SHALL have port tok_valid, output, 1 bit: one-cycle good-token pulse.
REQ-012 SHALL have port tok_pid, output, 4 bits: decoded PID.
REQ-013 SHALL have port tok_addr, output, 7 bits: address, or frame[6:0] for SOF.
REQ-014 SHALL have port tok_endp, output, 4 bits: endpoint, or frame[10:7] for SOF.
REQ-015 SHALL have port tok_err, output, 1 bit: one-cycle bad-packet pulse.
REQ-016 SHALL have port err_code, output, 2 bits: 0 PID, 1 CRC, 2 length, 3 line error; valid with tok_err.

Function
REQ-017 SHALL implement FSM states IDLE, DATA1, DATA2, EOPW, CHECK, DISCARD.
REQ-018 IDLE with rx_valid SHALL accept the byte as PID when rx_data[7:4] is the complement of rx_data[3:0] and rx_data[3:0] is one of OUT 4'b0001, IN 4'b1001, SETUP 4'b1101, SOF 4'b0101; it SHALL latch tok_pid, pulse crc_clr in the same cycle, and go to DATA1.
REQ-019 IDLE with any other PID byte SHALL go to DISCARD with a pending err_code of 0.
REQ-020 DATA1 and DATA2 with rx_valid SHALL set crc_data to rx_data and pulse crc_en in the same cycle; DATA1 goes to DATA2, DATA2 goes to EOPW.
REQ-021 The data bytes SHALL be latched as follows: tok_addr = byte1[6:0]; tok_endp = {byte2[2:0], byte1[7]}.
REQ-022 EOPW with rx_eop SHALL go to CHECK; EOPW with rx_valid (extra byte) SHALL go to DISCARD with err_code 2.
REQ-023 rx_eop in DATA1 or DATA2 SHALL pulse tok_err with err_code 2 in the next cycle and return to IDLE.
REQ-024 CHECK SHALL compare crc_in to residual 5'b01100; on a match it SHALL pulse tok_valid, otherwise tok_err with err_code 1; it then returns to IDLE; latency is one cycle after rx_eop.
REQ-025 rx_err in any state other than IDLE SHALL go to DISCARD with err_code 3; rx_err has priority over rx_valid and rx_eop.
REQ-026 DISCARD SHALL ignore bytes and, on rx_eop, pulse tok_err with the pending code and go to IDLE.
REQ-027 tok_pid, tok_addr and tok_endp SHALL hold their values until the next accepted PID.
REQ-028 tok_valid and tok_err SHALL never be high in the same cycle.

Reset
REQ-029 rst SHALL force the FSM to IDLE and all outputs to 0 immediately, including mid-packet; bytes arriving after rst is released and before the next rx_eop SHALL be treated as a new packet starting in IDLE.

Configuration
REQ-030 With USB_TOKEN_SOF_EN defined, the SOF PID SHALL be accepted as in REQ-018; without it, the SOF PID SHALL be a PID error (err_code 0).

Structure
REQ-031 Package usb_pkg SHALL hold the PID constants, the FSM state enum, the error-code enum and the CRC5 residual constant.
REQ-032 The block SHALL have no sub-module; CRC5 computation SHALL remain in the separate downstream CRC5 stage.

Verification
REQ-033 The bench SHALL cover: PID 8'hE1, bytes 8'h3A, 8'h05, rx_eop, crc_in=5'b01100 -> tok_valid; tok_pid=1, tok_addr=7'h3A, tok_endp=4'hA.
REQ-034 The bench SHALL cover: the same packet with crc_in=5'b00000 -> tok_err, err_code=1, with no tok_valid.
REQ-035 The bench SHALL cover: PID 8'hE2 (complement mismatch), then rx_eop -> tok_err, err_code=0; crc_en never asserted.
REQ-036 The bench SHALL cover: PID 8'h69, one byte, then rx_eop -> tok_err, err_code=2, the next cycle.
REQ-037 The bench SHALL cover: rst pulsed after byte1, then a full good packet -> exactly one tok_valid; crc_clr pulsed with the new PID.
REQ-038 The bench SHALL cover: PID 8'hA5 -> tok_valid when USB_TOKEN_SOF_EN is defined; tok_err with err_code=0 when it is not.
